// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
package imem_loader_pkg;

  // Default instruction-memory word-address width (64 words)
  localparam int ADDRBITS_DEF = 6;

  // Byte-lane geometry of one 32-bit instruction word
  localparam int BYTE_W     = 8;
  localparam int LANES      = 4;
  localparam int LANE_SEL_W = 2;
  localparam logic [LANE_SEL_W-1:0] LANE_FIRST = 2'd0;
  localparam logic [LANE_SEL_W-1:0] LANE_LAST  = 2'd3;

  // Loader state machine
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CSUM  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - 4-byte little-endian word assembler with clear and completion strobe
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clear,
  input  logic                      i_load,
  input  logic [BYTE_W-1:0]         i_byte,
  output logic [LANES*BYTE_W-1:0]   o_word,
  output logic                      o_complete
);

  logic [LANE_SEL_W-1:0]    r_lane;
  logic [LANES*BYTE_W-1:0]  r_word;
  logic [LANES*BYTE_W-1:0]  w_word;

  // Word as it looks with the incoming byte dropped into its lane; the
  // fourth byte is visible here in the same cycle it is accepted
  always_comb begin
    w_word = r_word;
    w_word[r_lane*BYTE_W +: BYTE_W] = i_byte;
  end

  assign o_word     = w_word;
  assign o_complete = i_load && (r_lane == LANE_LAST);

  // Lane pointer and partial word; clear discards any half-built word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lane <= LANE_FIRST;
      r_word <= '0;
    end else if (i_clear) begin
      r_lane <= LANE_FIRST;
      r_word <= '0;
    end else if (i_load) begin
      r_lane <= r_lane + 1'b1;
      r_word <= o_complete ? '0 : w_word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot byte stream to instruction memory loader; IMEM_LOADER_CSUM_EN adds a trailing XOR checksum byte
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDRBITS = ADDRBITS_DEF,
  parameter int WIDTH    = 32            // only 32 is supported
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                reload,
  output logic                imem_we,
  output logic [ADDRBITS-1:0] imem_wa,
  output logic [WIDTH-1:0]    imem_wd,
  output logic                cpu_reset,
  output logic                loaded,
  output logic                err
);

  state_t                r_state;
  logic [ADDRBITS-1:0]   r_nm1;
  logic [ADDRBITS-1:0]   r_idx;
  logic                  r_we;
  logic [ADDRBITS-1:0]   r_wa;
  logic [WIDTH-1:0]      r_wd;
  logic                  r_cpu_reset;
  logic                  r_loaded;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]            r_csum;
  logic                  r_err;
`endif

  logic                  w_accepting;
  logic                  w_fire;
  logic                  w_byte_load;
  logic                  w_complete;
  logic [WIDTH-1:0]      w_word;

  // A pending reload blocks acceptance so the restart never swallows a byte
  assign w_accepting = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_CSUM);
  assign in_ready    = w_accepting && !reload;
  assign w_fire      = in_valid && in_ready;
  assign w_byte_load = w_fire && (r_state == S_LOAD);

  byte_packer u_packer (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_clear    (reload),
    .i_load     (w_byte_load),
    .i_byte     (in_data),
    .o_word     (w_word),
    .o_complete (w_complete)
  );

  assign imem_we   = r_we;
  assign imem_wa   = r_wa;
  assign imem_wd   = r_wd;
  assign cpu_reset = r_cpu_reset;
  assign loaded    = r_loaded;
`ifdef IMEM_LOADER_CSUM_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

  // Loader FSM with registered memory-write and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_nm1       <= '0;
      r_idx       <= '0;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_cpu_reset <= 1'b1;
      r_loaded    <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      r_csum      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_we <= 1'b0;
      if (reload) begin
        r_state     <= S_IDLE;
        r_idx       <= '0;
        r_cpu_reset <= 1'b1;
        r_loaded    <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        r_csum      <= '0;
        r_err       <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_fire) begin
              r_nm1   <= in_data[ADDRBITS-1:0];
              r_state <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (w_fire) begin
`ifdef IMEM_LOADER_CSUM_EN
              r_csum <= r_csum ^ in_data;
`endif
              if (w_complete) begin
                r_we <= 1'b1;
                r_wa <= r_idx;
                r_wd <= w_word;
                if (r_idx == r_nm1) begin
`ifdef IMEM_LOADER_CSUM_EN
                  r_state  <= S_CSUM;
`else
                  // cpu_reset is released one edge later, in DONE, so it
                  // never drops while this final write pulse is high
                  r_state  <= S_DONE;
                  r_loaded <= 1'b1;
`endif
                end else begin
                  r_idx <= r_idx + 1'b1;
                end
              end
            end
          end
          S_CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
            if (w_fire) begin
              if (in_data == r_csum) begin
                r_state     <= S_DONE;
                r_loaded    <= 1'b1;
                r_cpu_reset <= 1'b0;
              end else begin
                r_state     <= S_ERROR;
                r_err       <= 1'b1;
              end
            end
`else
            r_state <= S_IDLE;
`endif
          end
          S_DONE: begin
            r_loaded    <= 1'b1;
            r_cpu_reset <= 1'b0;
          end
          S_ERROR: begin
            r_cpu_reset <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
